// File: rtl/mult_pkg.sv
// Shared constants and FSM state type for the shift-add multiplier.
package mult_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned PROD_W = 8;
  localparam int unsigned ITER_N = 4;
  localparam int unsigned CNT_W  = $clog2(ITER_N);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Operand pair as captured on an accepted start.
  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } operands_t;

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Request/result bundle of the shift-add multiplier; the requester is the master.
interface shift_add_multiplier_if;
  import mult_pkg::*;

  logic              start;
  logic [OP_W-1:0]   a;
  logic [OP_W-1:0]   b;
  logic              busy;
  logic              done;
  logic [PROD_W-1:0] product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );

endinterface

// File: rtl/mult_ctrl.sv
// Sequencer for the shift-add multiplier: IDLE/RUN/DONE FSM, iteration count,
// registered busy/done and combinational datapath strobes.
module mult_ctrl
  import mult_pkg::*;
(
  input  logic clk,
  input  logic clear_n,
  input  logic start,
  input  logic zero_op,
  output logic busy,
  output logic done,
  output logic accept_c,
  output logic bypass_c,
  output logic step_c,
  output logic last_c
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_c = 1'b0;
    bypass_c = 1'b0;
    step_c   = 1'b0;
    last_c   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept_c = 1'b1;
          cnt_d    = '0;
          if (zero_op) begin
            bypass_c = 1'b1;
            state_d  = DONE;
          end else begin
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        step_c = 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          last_c  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Flags follow the state being entered so they line up with it.
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: rtl/mux2.sv
// Width-parameterised 2:1 mux cell: y = sel ? d1 : d0.
module mux2 #(
  parameter int unsigned W = 4
) (
  input  logic         sel,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  output logic [W-1:0] y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/ripple_add4.sv
// 4-bit ripple-carry adder cell built from a chain of full adders.
module ripple_add4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  localparam int unsigned W = 4;

  logic [W:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int unsigned i = 0; i < W; i++) begin
      sum[i]     = x[i] ^ y[i] ^ carry[i];
      carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
    end
  end

  assign cout = carry[W];

endmodule

// File: rtl/shift_add_multiplier.sv
// 4x4 unsigned shift-add multiplier, one add+shift per RUN cycle.
// Optional MULT_ZERO_BYPASS_EN: zero operands skip RUN and finish in one cycle.
module shift_add_multiplier
  import mult_pkg::*;
(
  input  logic                   clk,
  input  logic                   clear_n,
  shift_add_multiplier_if.slave  bus
);

  localparam logic [OP_W-1:0] ZERO_OP = '0;

  logic [OP_W-1:0]   m_q, m_d;
  logic [OP_W-1:0]   q_q, q_d;
  logic [OP_W-1:0]   acc_q, acc_d;
  logic              c_q, c_d;
  logic [PROD_W-1:0] product_q, product_d;

  logic              accept_c, bypass_c, step_c, last_c;
  logic              zero_op_c;
  logic              busy_w, done_w;
  operands_t         ops_c;
  logic [OP_W-1:0]   addend_c, sum_c;
  logic              carry_c;
  logic [OP_W-1:0]   acc_sh_c, q_sh_c;

  assign ops_c = '{a: bus.a, b: bus.b};

`ifdef MULT_ZERO_BYPASS_EN
  assign zero_op_c = (ops_c.a == ZERO_OP) || (ops_c.b == ZERO_OP);
`else
  assign zero_op_c = 1'b0;
`endif

  mult_ctrl u_ctrl (
    .clk      (clk),
    .clear_n  (clear_n),
    .start    (bus.start),
    .zero_op  (zero_op_c),
    .busy     (busy_w),
    .done     (done_w),
    .accept_c (accept_c),
    .bypass_c (bypass_c),
    .step_c   (step_c),
    .last_c   (last_c)
  );

  // Partial product: M when the current multiplier LSB is set, else zero.
  mux2 #(.W(OP_W)) u_addend_mux (
    .sel (q_q[0]),
    .d0  (ZERO_OP),
    .d1  (m_q),
    .y   (addend_c)
  );

  ripple_add4 u_adder (
    .x    (acc_q),
    .y    (addend_c),
    .cin  (1'b0),
    .sum  (sum_c),
    .cout (carry_c)
  );

  // {C,ACC,Q} shifted right by one; ACC's LSB moves into Q's MSB.
  assign acc_sh_c = {carry_c, sum_c[OP_W-1:1]};
  assign q_sh_c   = {sum_c[0], q_q[OP_W-1:1]};

  always_comb begin
    m_d       = m_q;
    q_d       = q_q;
    acc_d     = acc_q;
    c_d       = c_q;
    product_d = product_q;

    if (accept_c) begin
      m_d   = ops_c.a;
      q_d   = ops_c.b;
      acc_d = '0;
      c_d   = 1'b0;
    end

    if (bypass_c) begin
      product_d = '0;
    end

    if (step_c) begin
      acc_d = acc_sh_c;
      q_d   = q_sh_c;
      c_d   = carry_c;
      if (last_c) begin
        product_d = {acc_sh_c, q_sh_c};
      end
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      m_q       <= '0;
      q_q       <= '0;
      acc_q     <= '0;
      c_q       <= 1'b0;
      product_q <= '0;
    end else begin
      m_q       <= m_d;
      q_q       <= q_d;
      acc_q     <= acc_d;
      c_q       <= c_d;
      product_q <= product_d;
    end
  end

  assign bus.busy    = busy_w;
  assign bus.done    = done_w;
  assign bus.product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: directed vector table,
// multi-cycle corner sequences, exhaustive sweep and random operations.
module tb_shift_add_multiplier;

  logic clk = 1'b0;
  logic clear_n;

  shift_add_multiplier_if bus ();

  shift_add_multiplier dut (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
    bit         scramble;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Edge (counted from the start-sampling edge) after which done is expected.
  function automatic int exp_done_edge(input logic [3:0] av, input logic [3:0] bv);
`ifdef MULT_ZERO_BYPASS_EN
    if (av == 4'd0 || bv == 4'd0) return 0;
`endif
    return 4;
  endfunction

  task automatic run_op(input string tag, input logic [3:0] av, input logic [3:0] bv,
                        input logic [7:0] pexp, input bit scramble);
    int         done_edge;
    int         busy_cycles;
    int         overlap;
    logic [7:0] prod;
    done_edge   = -1;
    busy_cycles = 0;
    overlap     = 0;
    prod        = '0;
    @(negedge clk);
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int e = 0; e < 12; e++) begin
      if (e > 0) begin
        @(posedge clk);
        #1;
      end
      if (bus.busy && bus.done) overlap++;
      if (bus.busy) busy_cycles++;
      if (bus.done) begin
        done_edge = e;
        prod      = bus.product;
        break;
      end
      if (scramble) begin
        bus.a = 4'($urandom);
        bus.b = 4'($urandom);
      end
    end
    chk({tag, " done_edge"}, done_edge, exp_done_edge(av, bv));
    chk({tag, " busy_cycles"}, busy_cycles, exp_done_edge(av, bv));
    chk({tag, " busy_done_overlap"}, overlap, 0);
    chk({tag, " product"}, int'(prod), int'(pexp));
    @(posedge clk);
    #1;
    chk({tag, " done_width"}, int'(bus.done), 0);
    chk({tag, " product_hold"}, int'(bus.product), int'(pexp));
  endtask

  initial begin
    int         first_done;
    int         second_done;
    logic [7:0] p1;
    logic [7:0] p2;
    int         seen;
    logic [3:0] ra;
    logic [3:0] rb;

    vecs[0]  = '{4'hF, 4'hF, 8'hE1, 1'b0};
    vecs[1]  = '{4'hD, 4'hB, 8'h8F, 1'b1};
    vecs[2]  = '{4'h3, 4'h5, 8'h0F, 1'b0};
    vecs[3]  = '{4'h7, 4'h9, 8'h3F, 1'b1};
    vecs[4]  = '{4'h0, 4'h9, 8'h00, 1'b0};
    vecs[5]  = '{4'h1, 4'h1, 8'h01, 1'b0};
    vecs[6]  = '{4'h8, 4'h2, 8'h10, 1'b1};
    vecs[7]  = '{4'hF, 4'h1, 8'h0F, 1'b0};
    vecs[8]  = '{4'h1, 4'hF, 8'h0F, 1'b1};
    vecs[9]  = '{4'hA, 4'h5, 8'h32, 1'b0};
    vecs[10] = '{4'h0, 4'h0, 8'h00, 1'b0};
    vecs[11] = '{4'hC, 4'hC, 8'h90, 1'b1};

    // Reset state
    clear_n   = 1'b0;
    bus.start = 1'b0;
    bus.a     = 4'd0;
    bus.b     = 4'd0;
    #1;
    chk("reset busy", int'(bus.busy), 0);
    chk("reset done", int'(bus.done), 0);
    chk("reset product", int'(bus.product), 0);
    repeat (2) @(negedge clk);
    clear_n = 1'b1;

    // Directed table
    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].scramble);
    end

    // Start held high: two back-to-back operations
    first_done  = -1;
    second_done = -1;
    p1          = '0;
    p2          = '0;
    @(negedge clk);
    bus.a     = 4'd3;
    bus.b     = 4'd5;
    bus.start = 1'b1;
    for (int e = 0; e < 16; e++) begin
      @(posedge clk);
      #1;
      if (e == 0) begin
        bus.a = 4'd7;
        bus.b = 4'd9;
      end
      if (bus.done) begin
        if (first_done < 0) begin
          first_done = e;
          p1         = bus.product;
        end else begin
          second_done = e;
          p2          = bus.product;
          break;
        end
      end
    end
    bus.start = 1'b0;
    chk("b2b first_done_edge", first_done, 4);
    chk("b2b done_spacing", second_done - first_done, 6);
    chk("b2b product1", int'(p1), 8'h0F);
    chk("b2b product2", int'(p2), 8'h3F);
    repeat (2) @(posedge clk);

    // Reset asserted after the 2nd RUN edge
    @(negedge clk);
    bus.a     = 4'hD;
    bus.b     = 4'hB;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    clear_n = 1'b0;
    #1;
    chk("midrun_reset busy", int'(bus.busy), 0);
    chk("midrun_reset done", int'(bus.done), 0);
    chk("midrun_reset product", int'(bus.product), 0);
    @(posedge clk);
    #1;
    chk("held_reset product", int'(bus.product), 0);
    @(negedge clk);
    clear_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) seen++;
    end
    chk("no_activity_after_reset", seen, 0);
    run_op("post_reset", 4'h6, 4'h7, 8'h2A, 1'b0);

    // Exhaustive sweep
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        run_op($sformatf("sweep_%0d_%0d", ia, ib), 4'(ia), 4'(ib), 8'(ia * ib), 1'b0);
      end
    end

    // Random operations with operand scrambling and idle gaps
    for (int k = 0; k < 40; k++) begin
      ra = 4'($urandom);
      rb = 4'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op($sformatf("rand%0d", k), ra, rb, 8'(ra) * 8'(rb), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 The block SHALL have a `clk` input, 1 bit wide, as its single clock; all state SHALL update on the rising edge.
REQ-002 The block SHALL have a `clear_n` input, 1 bit wide: asynchronous, active-low reset.
REQ-003 The block SHALL have a `start` input, 1 bit wide: request a multiply; sampled only in IDLE.
REQ-004 The block SHALL have an `a` input, 4 bits wide: unsigned multiplicand; sampled on the start edge.
REQ-005 The block SHALL have a `b` input, 4 bits wide: unsigned multiplier; sampled on the start edge.
REQ-006 The block SHALL have a `busy` output, 1 bit wide: high while in RUN.
REQ-007 The block SHALL have a `done` output, 1 bit wide: a one-cycle pulse while in DONE.
REQ-008 The block SHALL have a `product` output, 8 bits wide: the unsigned result, held until the next accepted start.

Function
REQ-009 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-010 In IDLE with start=1, the rising edge SHALL load: M=a, Q=b, ACC=0 (4 bits), C=0, cnt=0; the next state SHALL be RUN.
REQ-011 In IDLE with start=0, the FSM SHALL stay in IDLE with all registers unchanged.
REQ-012 Each RUN edge SHALL form {C,ACC} = ACC + (Q[0] ? M : 0) using a 4-bit ripple-carry add with carry-in 0 and an operand mux on Q[0].
REQ-013 On the same RUN edge, the block SHALL shift {C,ACC,Q} right by one, capturing the shifted-out value: ACC <= {C,ACC[3:1]}, Q <= {ACC[0],Q[3:1]}, and increment cnt.
REQ-014 On the RUN edge where cnt==3 (the 4th iteration), the next state SHALL be DONE and product SHALL be loaded with the post-shift {ACC,Q}.
REQ-015 Latency: with the start-sampling edge numbered 0, done SHALL be high between edges 4 and 5; busy SHALL be high between edges 0 and 4.
REQ-016 DONE SHALL last exactly one cycle and then return to IDLE unconditionally; start SHALL be ignored in DONE and in RUN.
REQ-017 A start held continuously high SHALL yield back-to-back operations, one accepted every 6 cycles (IDLE→RUN×4→DONE→IDLE).
REQ-018 Changes on a or b after the start edge SHALL NOT affect the operation in progress.
REQ-019 busy and done SHALL never be high in the same cycle.
REQ-020 All arithmetic SHALL be unsigned; 15×15=225 SHALL fit in the 8-bit product with no overflow condition.

Reset
REQ-021 While clear_n=0, the block SHALL immediately force state=IDLE, busy=0, done=0, product=0x00, and M, Q, ACC, C and cnt to 0, independent of clk.
REQ-022 A reset asserted mid-RUN SHALL abandon the operation with no done pulse.
REQ-023 After clear_n rises, the first start SHALL be accepted on the first rising edge at which clear_n=1 and start=1.

Configuration
REQ-024 The block SHALL support the macro MULT_ZERO_BYPASS_EN.
REQ-025 With MULT_ZERO_BYPASS_EN defined, a start accepted with a==0 or b==0 SHALL go IDLE→DONE directly, load product=0x00, and never assert busy; done SHALL be high between edges 0 and 1.
REQ-026 Without MULT_ZERO_BYPASS_EN, zero operands SHALL take the full 4-iteration path with the REQ-015 latency.

Structure
REQ-027 A shared package mult_pkg SHALL hold: the operand width constant (4), the product width constant (8), the iteration count constant (4), and the state typedef (IDLE, RUN, DONE).
REQ-028 The FSM, cnt and busy/done generation SHALL be a sub-module named mult_ctrl.
REQ-029 The datapath (M, Q, ACC, C, add, mux, shift) SHALL stay in the top level, reusing the team's existing 4-bit ripple adder and 2:1 mux cells.

Verification
REQ-030 The bench SHALL apply a=4'hF, b=4'hF with a single-cycle start → product=8'hE1, and done high between edges 4 and 5.
REQ-031 The bench SHALL apply a=4'hD, b=4'hB → product=8'h8F; busy high for exactly 4 cycles; changing a and b during RUN SHALL leave the result unchanged.
REQ-032 The bench SHALL hold start=1 continuously with a=3, b=5, then a=7, b=9 → product=8'h0F, then 8'h3F, with done pulses 6 cycles apart.
REQ-033 The bench SHALL drive clear_n=0 after the 2nd RUN edge → busy=0, done=0 and product=0x00 immediately, and no done pulse SHALL follow.
REQ-034 The bench SHALL apply a=0, b=9 → product=8'h00; with MULT_ZERO_BYPASS_EN, done SHALL be high between edges 0 and 1 and busy SHALL never assert; without it, done SHALL be high between edges 4 and 5.
REQ-035 The bench SHALL run an exhaustive sweep of all 256 a/b pairs → product==a*b for every pair, and the REQ-019 check (busy and done never both high) SHALL never fail.
